// File: rtl/vec_store_serializer.sv
// vec_store_serializer: drains one captured V-lane vector into scalar memory,
// one masked-in lane per accepted write, at ascending addresses from a base.
module vec_store_serializer #(
    parameter int N  = 20,
    parameter int V  = 8,
    parameter int AW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [V-1:0]    lane_mask,
    input  logic [V*N-1:0]  vec_data,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [N-1:0]    mem_wdata,
    output logic            busy,
    output logic            done
);
    localparam int LW = (V > 1) ? $clog2(V) : 1;
    localparam int IW = LW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [V*N-1:0] r_data;
    logic [V-1:0]  r_mask;
    logic [AW-1:0] r_base;
    logic [IW-1:0] r_idx;
    logic [LW-1:0] r_cur;

    logic          w_found;
    logic [LW-1:0] w_sel;
    logic          w_last;

    // Lowest set mask bit at or above the current lane index.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = V - 1; i >= 0; i--) begin
            if (r_mask[i] && (IW'(i) >= r_idx)) begin
                w_found = 1'b1;
                w_sel   = LW'(i);
            end
        end
    end

    assign w_last = (r_cur == LW'(V - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_mask    <= '0;
            r_base    <= '0;
            r_idx     <= '0;
            r_cur     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data  <= vec_data;
                        r_mask  <= lane_mask;
                        r_base  <= base_addr;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_found) begin
                        r_cur     <= w_sel;
                        mem_we    <= 1'b1;
                        mem_addr  <= r_base + AW'(w_sel);
                        mem_wdata <= r_data[w_sel*N +: N];
                        r_state   <= S_WRITE;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        r_idx  <= IW'(r_cur) + IW'(1);
                        if (w_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_store_serializer.sv
// Directed bench for vec_store_serializer: ordering, masking, backpressure,
// address wrap, ignored starts and reset abort.
module tb_vec_store_serializer;
    localparam int N  = 20;
    localparam int V  = 8;
    localparam int AW = 16;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [V-1:0]    lane_mask;
    logic [V*N-1:0]  vec_data;
    logic            mem_ready;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [N-1:0]    mem_wdata;
    logic            busy;
    logic            done;

    vec_store_serializer #(.N(N), .V(V), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .lane_mask(lane_mask), .vec_data(vec_data), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] wr_addr [32];
    logic [N-1:0]  wr_data [32];
    int n_wr, n_done, done_cyc, busy_first, busy_last, n_busy;
    logic          st_we   [8];
    logic [AW-1:0] st_addr [8];
    logic [N-1:0]  st_data [8];
    int n_st;

    logic [AW-1:0] ex_addr [16];
    logic [N-1:0]  ex_data [16];
    int n_ex;

    function automatic logic [V*N-1:0] mkvec(input logic [N-1:0] b);
        logic [V*N-1:0] v;
        for (int i = 0; i < V; i++) v[i*N +: N] = b + N'(i);
        return v;
    endfunction

    // Drives one transfer and records what came out; cycle 0 is the start edge.
    task automatic run_xfer(input logic [AW-1:0] base, input logic [V-1:0] mask,
                            input logic [V*N-1:0] data, input int stall_lane,
                            input int stall_n, input int inj_cyc, input int budget);
        int stall_left;
        int stop;
        int k;
        logic [AW-1:0] stall_addr;
        n_wr = 0; n_done = 0; done_cyc = -1;
        busy_first = -1; busy_last = -1; n_busy = 0; n_st = 0;
        stall_left = stall_n;
        stall_addr = base + AW'(stall_lane);
        stop = budget;
        @(negedge clk);
        base_addr = base; lane_mask = mask; vec_data = data;
        start = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        k = 0;
        while (k < stop) begin
            k++;
            @(negedge clk);
            start = 1'b0;
            mem_ready = 1'b1;
            if (k == inj_cyc) begin
                base_addr = ~base;
                lane_mask = V'(15);
                vec_data  = ~data;
                start     = 1'b1;
            end
            if (stall_left > 0 && mem_we && mem_addr == stall_addr) begin
                mem_ready = 1'b0;
                st_we[n_st] = mem_we; st_addr[n_st] = mem_addr;
                st_data[n_st] = mem_wdata;
                n_st++; stall_left--;
            end
            if (mem_we && mem_ready && n_wr < 32) begin
                wr_addr[n_wr] = mem_addr; wr_data[n_wr] = mem_wdata; n_wr++;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k; n_busy++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    if (k + 2 < stop) stop = k + 2;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b1;
        base_addr = '0; lane_mask = '0; vec_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", mem_we); end
        n_checks++;
        if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        n_checks++;
        if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_full();
        run_xfer(16'h0100, 8'hFF, mkvec(20'h10000), 0, 0, -1, 60);
        n_checks++;
        if (n_wr !== 8) begin n_fail++; $display("FAIL full_nwr got %0d want 8", n_wr); end
        for (int i = 0; i < 8 && i < n_wr; i++) begin
            n_checks++;
            if (wr_addr[i] !== 16'h0100 + AW'(i) || wr_data[i] !== 20'h10000 + N'(i)) begin
                n_fail++;
                $display("FAIL full_wr%0d got %h/%h want %h/%h", i, wr_addr[i], wr_data[i],
                         16'h0100 + AW'(i), 20'h10000 + N'(i));
            end
        end
        n_checks++;
        if (done_cyc !== 17 || n_done !== 1) begin
            n_fail++; $display("FAIL full_done got cyc %0d n %0d want 17 1", done_cyc, n_done);
        end
        n_checks++;
        if (busy_first !== 1 || busy_last !== 16 || n_busy !== 16) begin
            n_fail++;
            $display("FAIL full_busy got %0d..%0d n %0d want 1..16 n 16", busy_first, busy_last, n_busy);
        end
    endtask

    task automatic test_sparse();
        run_xfer(16'h0020, 8'b10100001, mkvec(20'h20000), 0, 0, -1, 60);
        n_ex = 3;
        ex_addr[0] = 16'h0020; ex_data[0] = 20'h20000;
        ex_addr[1] = 16'h0025; ex_data[1] = 20'h20005;
        ex_addr[2] = 16'h0027; ex_data[2] = 20'h20007;
        n_checks++;
        if (n_wr !== n_ex) begin n_fail++; $display("FAIL sparse_nwr got %0d want %0d", n_wr, n_ex); end
        for (int i = 0; i < n_ex && i < n_wr; i++) begin
            n_checks++;
            if (wr_addr[i] !== ex_addr[i] || wr_data[i] !== ex_data[i]) begin
                n_fail++;
                $display("FAIL sparse_wr%0d got %h/%h want %h/%h", i, wr_addr[i], wr_data[i],
                         ex_addr[i], ex_data[i]);
            end
        end
        n_checks++;
        if (done_cyc !== 7 || n_done !== 1) begin
            n_fail++; $display("FAIL sparse_done got cyc %0d n %0d want 7 1", done_cyc, n_done);
        end
    endtask

    task automatic test_backpressure();
        run_xfer(16'h0200, 8'hFF, mkvec(20'h40000), 2, 4, -1, 80);
        n_checks++;
        if (n_st !== 4) begin n_fail++; $display("FAIL bp_nstall got %0d want 4", n_st); end
        for (int i = 0; i < n_st; i++) begin
            n_checks++;
            if (st_we[i] !== 1'b1 || st_addr[i] !== 16'h0202 || st_data[i] !== 20'h40002) begin
                n_fail++;
                $display("FAIL bp_hold%0d got %b/%h/%h want 1/0202/40002", i, st_we[i],
                         st_addr[i], st_data[i]);
            end
        end
        n_checks++;
        if (n_wr !== 8) begin n_fail++; $display("FAIL bp_nwr got %0d want 8", n_wr); end
        for (int i = 0; i < 8 && i < n_wr; i++) begin
            n_checks++;
            if (wr_addr[i] !== 16'h0200 + AW'(i) || wr_data[i] !== 20'h40000 + N'(i)) begin
                n_fail++;
                $display("FAIL bp_wr%0d got %h/%h want %h/%h", i, wr_addr[i], wr_data[i],
                         16'h0200 + AW'(i), 20'h40000 + N'(i));
            end
        end
        n_checks++;
        if (done_cyc !== 21 || n_done !== 1) begin
            n_fail++; $display("FAIL bp_done got cyc %0d n %0d want 21 1", done_cyc, n_done);
        end
    endtask

    task automatic test_wrap_empty();
        run_xfer(16'hFFFE, 8'h0C, mkvec(20'h50000), 0, 0, -1, 40);
        n_checks++;
        if (n_wr !== 2) begin n_fail++; $display("FAIL wrap_nwr got %0d want 2", n_wr); end
        n_checks++;
        if (wr_addr[0] !== 16'h0000 || wr_data[0] !== 20'h50002) begin
            n_fail++; $display("FAIL wrap_wr0 got %h/%h want 0000/50002", wr_addr[0], wr_data[0]);
        end
        n_checks++;
        if (wr_addr[1] !== 16'h0001 || wr_data[1] !== 20'h50003) begin
            n_fail++; $display("FAIL wrap_wr1 got %h/%h want 0001/50003", wr_addr[1], wr_data[1]);
        end
        n_checks++;
        if (done_cyc !== 6) begin n_fail++; $display("FAIL wrap_done got %0d want 6", done_cyc); end
        run_xfer(16'h0040, 8'h00, mkvec(20'h60000), 0, 0, -1, 20);
        n_checks++;
        if (n_wr !== 0) begin n_fail++; $display("FAIL empty_nwr got %0d want 0", n_wr); end
        n_checks++;
        if (done_cyc !== 2 || n_done !== 1 || n_busy !== 1) begin
            n_fail++;
            $display("FAIL empty_done got cyc %0d n %0d busy %0d want 2 1 1", done_cyc, n_done, n_busy);
        end
    endtask

    task automatic test_start_busy();
        run_xfer(16'h0300, 8'hFF, mkvec(20'h30000), 0, 0, 5, 60);
        n_checks++;
        if (n_wr !== 8) begin n_fail++; $display("FAIL sb_nwr got %0d want 8", n_wr); end
        for (int i = 0; i < 8 && i < n_wr; i++) begin
            n_checks++;
            if (wr_addr[i] !== 16'h0300 + AW'(i) || wr_data[i] !== 20'h30000 + N'(i)) begin
                n_fail++;
                $display("FAIL sb_wr%0d got %h/%h want %h/%h", i, wr_addr[i], wr_data[i],
                         16'h0300 + AW'(i), 20'h30000 + N'(i));
            end
        end
        n_checks++;
        if (done_cyc !== 17) begin n_fail++; $display("FAIL sb_done got %0d want 17", done_cyc); end
        // Start raised in the DONE cycle must not launch another transfer.
        run_xfer(16'h0380, 8'hFF, mkvec(20'h38000), 0, 0, 17, 60);
        n_checks++;
        if (done_cyc !== 17 || busy_last !== 16 || n_wr !== 8) begin
            n_fail++;
            $display("FAIL sd_ignore got done %0d busy_last %0d nwr %0d want 17 16 8",
                     done_cyc, busy_last, n_wr);
        end
    endtask

    task automatic test_reset_abort();
        int seen_we;
        int n_we_after;
        int n_done_after;
        @(negedge clk);
        base_addr = 16'h0400; lane_mask = 8'hFF; vec_data = mkvec(20'h70000);
        start = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        seen_we = 0;
        for (int k = 0; k < 6 && seen_we == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_we) seen_we = 1;
        end
        n_checks++;
        if (seen_we !== 1) begin n_fail++; $display("FAIL ra_reach_write got 0 want 1"); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL ra_outs got we %b busy %b done %b want 0 0 0", mem_we, busy, done);
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL ra_clear got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        n_we_after = 0; n_done_after = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we) n_we_after++;
            if (done || busy) n_done_after++;
        end
        n_checks++;
        if (n_we_after !== 0 || n_done_after !== 0) begin
            n_fail++;
            $display("FAIL ra_quiet got we %0d done/busy %0d want 0 0", n_we_after, n_done_after);
        end
        run_xfer(16'h0500, 8'hFF, mkvec(20'h80000), 0, 0, -1, 60);
        n_checks++;
        if (n_wr !== 8 || done_cyc !== 17 || wr_addr[7] !== 16'h0507 || wr_data[7] !== 20'h80007) begin
            n_fail++;
            $display("FAIL ra_fresh got nwr %0d done %0d last %h/%h want 8 17 0507/80007",
                     n_wr, done_cyc, wr_addr[7], wr_data[7]);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_backpressure();
        test_wrap_empty();
        test_start_busy();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
